// File: rtl/vid_sram_reader.sv
// Purpose: sweeps the banked vertex-ID SRAMs after an epoch and streams every filled row out, one bank row per beat.
// Latency: the first beat is valid 3 cycles after start. Each address costs 2 fetch cycles plus one cycle per emitted row.
// Backpressure: out_ready low freezes the DRAIN state, so all out_* signals hold until the beat is accepted.
module vid_sram_reader #(
    parameter int K          = 16,
    parameter int Q          = 16,
    parameter int VID_BW     = 16,
    parameter int ADDR_SPACE = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [K*(ADDR_SPACE+1)-1:0]   in_bank_cnt,
    output logic [ADDR_SPACE-1:0]         vid_sram_raddr,
    input  logic [K*Q*VID_BW-1:0]         vid_sram_rdata_all,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [Q*VID_BW-1:0]           out_data,
    output logic [3:0]                    out_bank,
    output logic [ADDR_SPACE-1:0]         out_addr,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    localparam int CNT_W = ADDR_SPACE + 1;
    localparam int ROW_W = Q * VID_BW;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_SPACE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]      cnt [K];
    logic [CNT_W-1:0]      max_cnt;
    logic [ADDR_SPACE-1:0] a;
    logic [K-1:0]          mask;
    logic [ROW_W-1:0]      row_buf [K];

    logic [CNT_W-1:0]      cnt_clamped [K];
    logic [CNT_W-1:0]      cnt_max_in;
    logic [K-1:0]          mask_new;
    logic [K-1:0]          mask_rest;
    logic [CNT_W-1:0]      a_inc;
    logic [3:0]            sel;
    logic                  fire;

    // Clamp the live fill counts to the SRAM depth and find the deepest bank.
    always_comb begin
        cnt_max_in = '0;
        for (int b = 0; b < K; b++) begin
            cnt_clamped[b] = in_bank_cnt[b*CNT_W +: CNT_W];
            if (cnt_clamped[b] > DEPTH) begin
                cnt_clamped[b] = DEPTH;
            end
            if (cnt_clamped[b] > cnt_max_in) begin
                cnt_max_in = cnt_clamped[b];
            end
        end
    end

    // Banks with an entry at the current address; the mask is never empty while a < max_cnt.
    always_comb begin
        mask_new = '0;
        for (int b = 0; b < K; b++) begin
            mask_new[b] = (CNT_W'(a) < cnt[b]);
        end
    end

    // Lowest pending bank goes out first, so beats are bank-ascending within an address.
    always_comb begin
        sel = '0;
        for (int b = K - 1; b >= 0; b--) begin
            if (mask[b]) begin
                sel = 4'(b);
            end
        end
    end

    assign mask_rest = mask & (mask - K'(1));
    assign a_inc     = CNT_W'(a) + CNT_W'(1);
    assign fire      = (state == S_DRAIN) && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and beat outputs; outputs are zeroed whenever no beat is on offer.
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_data  = '0;
        out_bank  = '0;
        out_addr  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (cnt_max_in == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy      = 1'b1;
                state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = row_buf[sel];
                out_bank  = sel;
                out_addr  = a;
                out_last  = (mask_rest == '0) && (a_inc == max_cnt);
                if (fire && (mask_rest == '0)) begin
                    state_nxt = (a_inc < max_cnt) ? S_ISSUE : S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sweep control: latch counts on start, build the emit mask in WAIT, step the address when a row set drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            a              <= '0;
            vid_sram_raddr <= '0;
            max_cnt        <= '0;
            mask           <= '0;
            for (int b = 0; b < K; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int b = 0; b < K; b++) begin
                            cnt[b] <= cnt_clamped[b];
                        end
                        max_cnt        <= cnt_max_in;
                        a              <= '0;
                        vid_sram_raddr <= '0;
                    end
                end
                S_WAIT: begin
                    mask <= mask_new;
                end
                S_DRAIN: begin
                    if (fire) begin
                        mask <= mask_rest;
                        if ((mask_rest == '0) && (a_inc < max_cnt)) begin
                            a              <= a_inc[ADDR_SPACE-1:0];
                            vid_sram_raddr <= a_inc[ADDR_SPACE-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Row capture while the SRAM read data is valid; out_data is gated outside DRAIN so no reset is needed here.
    always_ff @(posedge clk) begin
        if (state == S_WAIT) begin
            for (int b = 0; b < K; b++) begin
                row_buf[b] <= vid_sram_rdata_all[b*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: tb/tb_vid_sram_reader.sv
// Bench for vid_sram_reader: registered-read SRAM model plus directed sweeps.
// Each scenario task drives a sweep and compares the collected beats against a bench-built expected list.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_vid_sram_reader;

    localparam int K     = 16;
    localparam int CW    = 5;
    localparam int AS    = 4;
    localparam int ROW_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [K*CW-1:0]   in_bank_cnt;
    logic [AS-1:0]     vid_sram_raddr;
    logic [K*ROW_W-1:0] rdata_all;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_data;
    logic [3:0]        out_bank;
    logic [AS-1:0]     out_addr;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    // Beats accepted by the bench, and the beats it expects.
    int               ob_bank[$];
    int               ob_addr[$];
    logic [ROW_W-1:0] ob_data[$];
    bit               ob_last[$];
    int               eb_bank[$];
    int               eb_addr[$];

    int first_valid_cyc;
    int done_cyc;
    int stall_viol;
    int valid_seen;
    int busy_seen;

    vid_sram_reader dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .in_bank_cnt        (in_bank_cnt),
        .vid_sram_raddr     (vid_sram_raddr),
        .vid_sram_rdata_all (rdata_all),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_bank           (out_bank),
        .out_addr           (out_addr),
        .out_last           (out_last),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    // Preloaded SRAM contents: every vertex ID encodes its bank, address and lane.
    function automatic logic [ROW_W-1:0] row_val(input int b, input int a);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int q = 0; q < 16; q++) begin
            r[q*16 +: 16] = {4'(b), 4'(a), 4'(q), 4'(b ^ a ^ 10)};
        end
        return r;
    endfunction

    // Banks sample the read address at the edge; data is valid the following cycle.
    always @(posedge clk) begin
        for (int b = 0; b < K; b++) begin
            rdata_all[b*ROW_W +: ROW_W] <= row_val(b, int'(vid_sram_raddr));
        end
    end

    // Expected beat order: address-major, bank-minor, counts clamped to 16.
    function automatic void build_expected(input logic [K*CW-1:0] cnts);
        int c;
        eb_bank.delete();
        eb_addr.delete();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < K; b++) begin
                c = int'(cnts[b*CW +: CW]);
                if (c > 16) c = 16;
                if (a < c) begin
                    eb_bank.push_back(b);
                    eb_addr.push_back(a);
                end
            end
        end
    endfunction

    // Index of the first collected beat that differs from the expected list, or -1.
    function automatic int first_bad_beat();
        int n;
        n = (ob_bank.size() < eb_bank.size()) ? ob_bank.size() : eb_bank.size();
        for (int i = 0; i < n; i++) begin
            if (ob_bank[i] != eb_bank[i] || ob_addr[i] != eb_addr[i] ||
                ob_data[i] !== row_val(eb_bank[i], eb_addr[i]) ||
                ob_last[i] != (i == eb_bank.size() - 1)) begin
                return i;
            end
        end
        return -1;
    endfunction

    // Start a sweep and record every accepted beat until done or the cycle budget runs out.
    task automatic run_sweep(input logic [K*CW-1:0] cnts, input int ready_pct,
                             input int restart_at, input int max_cyc);
        int               cyc;
        bit               stalled;
        int               pb;
        int               pa;
        logic [ROW_W-1:0] pd;
        ob_bank.delete();
        ob_addr.delete();
        ob_data.delete();
        ob_last.delete();
        first_valid_cyc = -1;
        done_cyc        = -1;
        stall_viol      = 0;
        valid_seen      = 0;
        busy_seen       = 0;
        stalled         = 1'b0;
        pb              = 0;
        pa              = 0;
        pd              = '0;
        out_ready       = 1'b0;
        start           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_bank_cnt = cnts;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        in_bank_cnt = '1;
        cyc = 1;
        while (cyc <= max_cyc) begin
            if (out_valid === 1'b1) begin
                valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (busy === 1'b1) busy_seen++;
            if (stalled && (out_valid !== 1'b1 || int'(out_bank) != pb ||
                            int'(out_addr) != pa || out_data !== pd)) begin
                stall_viol++;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            out_ready = (ready_pct >= 100) || ($urandom_range(99) < ready_pct);
            start     = (cyc == restart_at);
            if (out_valid === 1'b1 && out_ready) begin
                ob_bank.push_back(int'(out_bank));
                ob_addr.push_back(int'(out_addr));
                ob_data.push_back(out_data);
                ob_last.push_back(out_last);
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            pb      = int'(out_bank);
            pa      = int'(out_addr);
            pd      = out_data;
            @(posedge clk);
            #1;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        out_ready   = 1'b0;
        in_bank_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (out_bank !== 4'd0) begin n_fail++; $display("FAIL reset_out_bank: got %0d expected 0", out_bank); end
        n_checks++; if (out_addr !== 4'd0) begin n_fail++; $display("FAIL reset_out_addr: got %0d expected 0", out_addr); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (vid_sram_raddr !== 4'd0) begin n_fail++; $display("FAIL reset_raddr: got %0d expected 0", vid_sram_raddr); end
        rst = 1'b0;
    endtask

    task automatic test_all_zero();
        run_sweep('0, 100, -1, 20);
        n_checks++; if (done_cyc != 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        n_checks++; if (valid_seen != 0) begin n_fail++; $display("FAIL zero_no_valid: got %0d valid cycles expected 0", valid_seen); end
        n_checks++; if (busy_seen != 0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_seen); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_in_done: got %b expected 0", busy); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", done); end
    endtask

    task automatic test_single_bank();
        logic [K*CW-1:0] c;
        c = '0;
        c[3*CW +: CW] = 5'd1;
        build_expected(c);
        run_sweep(c, 100, -1, 40);
        n_checks++; if (ob_bank.size() != 1) begin n_fail++; $display("FAIL single_beats: got %0d expected 1", ob_bank.size()); end
        n_checks++; if (first_valid_cyc != 3) begin n_fail++; $display("FAIL single_latency: got %0d expected 3", first_valid_cyc); end
        n_checks++; if (first_bad_beat() != -1) begin n_fail++; $display("FAIL single_beat_content: first bad beat %0d expected none", first_bad_beat()); end
        n_checks++; if (done_cyc != 4) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 4", done_cyc); end
    endtask

    task automatic test_all_full();
        build_expected({K{5'd16}});
        run_sweep({K{5'd16}}, 100, -1, 600);
        n_checks++; if (ob_bank.size() != 256) begin n_fail++; $display("FAIL full_beats: got %0d expected 256", ob_bank.size()); end
        n_checks++; if (first_bad_beat() != -1) begin n_fail++; $display("FAIL full_order: first bad beat %0d expected none", first_bad_beat()); end
        n_checks++; if (first_valid_cyc != 3) begin n_fail++; $display("FAIL full_latency: got %0d expected 3", first_valid_cyc); end
        n_checks++; if (done_cyc != 289) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected 289", done_cyc); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_after_done: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_staggered();
        logic [K*CW-1:0] c;
        for (int b = 0; b < K; b++) c[b*CW +: CW] = 5'(b);
        build_expected(c);
        run_sweep(c, 60, -1, 2000);
        n_checks++; if (ob_bank.size() != 120) begin n_fail++; $display("FAIL stagger_beats: got %0d expected 120", ob_bank.size()); end
        n_checks++; if (first_bad_beat() != -1) begin n_fail++; $display("FAIL stagger_order: first bad beat %0d expected none", first_bad_beat()); end
        n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL stagger_stall_hold: got %0d changed stalled beats expected 0", stall_viol); end
        n_checks++; if (done_cyc < 0) begin n_fail++; $display("FAIL stagger_timeout: got done_cyc %0d expected completion", done_cyc); end
    endtask

    task automatic test_restart_ignored();
        build_expected({K{5'd16}});
        run_sweep({K{5'd16}}, 100, 50, 600);
        n_checks++; if (ob_bank.size() != 256) begin n_fail++; $display("FAIL restart_beats: got %0d expected 256", ob_bank.size()); end
        n_checks++; if (first_bad_beat() != -1) begin n_fail++; $display("FAIL restart_order: first bad beat %0d expected none", first_bad_beat()); end
        n_checks++; if (done_cyc != 289) begin n_fail++; $display("FAIL restart_done_cycle: got %0d expected 289", done_cyc); end
    endtask

    task automatic test_clamp();
        logic [K*CW-1:0] c;
        c = '0;
        c[0*CW +: CW]  = 5'd20;
        c[5*CW +: CW]  = 5'd2;
        c[15*CW +: CW] = 5'd17;
        build_expected(c);
        run_sweep(c, 100, -1, 300);
        n_checks++; if (ob_bank.size() != 34) begin n_fail++; $display("FAIL clamp_beats: got %0d expected 34", ob_bank.size()); end
        n_checks++; if (first_bad_beat() != -1) begin n_fail++; $display("FAIL clamp_order: first bad beat %0d expected none", first_bad_beat()); end
        n_checks++; if (done_cyc != 67) begin n_fail++; $display("FAIL clamp_done_cycle: got %0d expected 67", done_cyc); end
    endtask

    task automatic test_reset_mid_sweep();
        int bad;
        repeat (2) @(posedge clk);
        #1;
        in_bank_cnt = {K{5'd16}};
        start       = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_bank !== 4'd5) begin n_fail++; $display("FAIL midrst_beat5: got valid=%b bank=%0d expected 1 5", out_valid, out_bank); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (vid_sram_raddr !== 4'd0) begin n_fail++; $display("FAIL midrst_raddr: got %0d expected 0", vid_sram_raddr); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (done !== 1'b0 || out_valid !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
        build_expected({K{5'd16}});
        run_sweep({K{5'd16}}, 100, -1, 600);
        n_checks++; if (ob_bank.size() != 256) begin n_fail++; $display("FAIL midrst_rerun_beats: got %0d expected 256", ob_bank.size()); end
        n_checks++; if (first_bad_beat() != -1) begin n_fail++; $display("FAIL midrst_rerun_order: first bad beat %0d expected none", first_bad_beat()); end
        n_checks++; if (done_cyc != 289) begin n_fail++; $display("FAIL midrst_rerun_done: got %0d expected 289", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_bank();
        test_all_full();
        test_staggered();
        test_restart_ignored();
        test_clamp();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
